// File: rtl/riscv_mem.sv
// riscv_mem: dual-port word memory for a RISC-V hart.
// Fetch port is read-only, data port is read/write with byte enables.
// Both ports return a response a fixed LATENCY cycles after each request and
// flag misaligned or out-of-range addresses.
// Optional feature macro: RISCV_MEM_STATS_EN (adds rd_count / wr_count).
module riscv_mem #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [XLEN-1:0]   i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN/8-1:0] d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_err
`ifdef RISCV_MEM_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((XLEN % 8) != 0 || LATENCY < 1 || LATENCY > 4) begin : g_bad_cfg
    $fatal(1, "riscv_mem: XLEN must be a multiple of 8 and LATENCY in 1..4");
  end

  logic [XLEN-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_i_idx;
  logic [ADDR_W-1:0] w_d_idx;
  logic              w_i_err;
  logic              w_d_err;
  logic [XLEN-1:0]   w_i_mem;
  logic [XLEN-1:0]   w_d_mem;
  logic              w_i_rd_ok;
  logic              w_d_rd_ok;
  logic              w_d_wr_ok;

  // Address decode: word index, misalignment and range checks for both ports
  always_comb begin
    w_i_idx   = i_addr >> OFF_W;
    w_d_idx   = d_addr >> OFF_W;
    w_i_err   = ((i_addr & ADDR_W'(NB - 1)) != '0) || (w_i_idx >= ADDR_W'(DEPTH));
    w_d_err   = ((d_addr & ADDR_W'(NB - 1)) != '0) || (w_d_idx >= ADDR_W'(DEPTH));
    w_i_mem   = r_mem[w_i_idx[IDX_W-1:0]];
    w_d_mem   = r_mem[w_d_idx[IDX_W-1:0]];
    w_i_rd_ok = i_req && !w_i_err;
    w_d_rd_ok = d_req && !d_we && !w_d_err;
    w_d_wr_ok = d_req && d_we && !w_d_err;
  end

  // Storage write with byte enables; array contents survive reset
  always_ff @(posedge clk) begin
    if (w_d_wr_ok) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (d_be[b]) begin
          r_mem[w_d_idx[IDX_W-1:0]][8*b +: 8] <= d_wdata[8*b +: 8];
        end
      end
    end
  end

  logic [LATENCY-1:0] r_i_vld;
  logic [LATENCY-1:0] r_i_err;
  logic [XLEN-1:0]    r_i_data [LATENCY];
  logic [LATENCY-1:0] r_d_vld;
  logic [LATENCY-1:0] r_d_err;
  logic [XLEN-1:0]    r_d_data [LATENCY];

  // Response pipelines: stage 0 captures the array at the accept edge
  // (fetch sees pre-write contents), later stages shift toward the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_vld <= '0;
      r_i_err <= '0;
      r_d_vld <= '0;
      r_d_err <= '0;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        r_i_data[s] <= '0;
        r_d_data[s] <= '0;
      end
    end else begin
      r_i_vld[0]  <= i_req;
      r_i_err[0]  <= i_req && w_i_err;
      r_i_data[0] <= w_i_rd_ok ? w_i_mem : '0;
      r_d_vld[0]  <= d_req;
      r_d_err[0]  <= d_req && w_d_err;
      r_d_data[0] <= w_d_rd_ok ? w_d_mem : '0;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        r_i_vld[s]  <= r_i_vld[s-1];
        r_i_err[s]  <= r_i_err[s-1];
        r_i_data[s] <= r_i_data[s-1];
        r_d_vld[s]  <= r_d_vld[s-1];
        r_d_err[s]  <= r_d_err[s-1];
        r_d_data[s] <= r_d_data[s-1];
      end
    end
  end

  // Outputs come straight from the last pipeline stage
  always_comb begin
    i_rvalid = r_i_vld[LATENCY-1];
    i_err    = r_i_err[LATENCY-1];
    i_rdata  = r_i_data[LATENCY-1];
    d_rvalid = r_d_vld[LATENCY-1];
    d_err    = r_d_err[LATENCY-1];
    d_rdata  = r_d_data[LATENCY-1];
  end

`ifdef RISCV_MEM_STATS_EN
  logic [1:0]  w_rd_inc;
  logic [32:0] w_rd_sum;

  // Reads this cycle from both ports, added to the count in one step
  always_comb begin
    w_rd_inc = {1'b0, w_i_rd_ok} + {1'b0, w_d_rd_ok};
    w_rd_sum = {1'b0, rd_count} + 33'(w_rd_inc);
  end

  // Saturating accepted-access counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      rd_count <= w_rd_sum[32] ? '1 : w_rd_sum[31:0];
      if (w_d_wr_ok && (wr_count != '1)) begin
        wr_count <= wr_count + 32'd1;
      end
    end
  end
`endif

endmodule
